// File: rtl/l2_cacheline_adaptor.sv
// Bridges the L2 line-wide memory port to a burst-beat DRAM interface:
// line reads are assembled from BEATS beats, line writes are split into BEATS beats.
module l2_cacheline_adaptor #(
  parameter int LINE_WIDTH  = 256,
  parameter int BURST_WIDTH = 64,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   line_read_i,
  input  logic                   line_write_i,
  input  logic [ADDR_WIDTH-1:0]  line_addr_i,
  input  logic [LINE_WIDTH-1:0]  line_wdata_i,
  output logic [LINE_WIDTH-1:0]  line_rdata_o,
  output logic                   line_resp_o,
  output logic                   mem_read_o,
  output logic                   mem_write_o,
  output logic [ADDR_WIDTH-1:0]  mem_addr_o,
  output logic [BURST_WIDTH-1:0] mem_wdata_o,
  input  logic [BURST_WIDTH-1:0] mem_rdata_i,
  input  logic                   mem_resp_i
);

  localparam int BEATS = LINE_WIDTH / BURST_WIDTH;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFF_W = $clog2(LINE_WIDTH / 8);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  generate
    if ((BEATS * BURST_WIDTH != LINE_WIDTH) || ((BEATS & (BEATS - 1)) != 0) || (BEATS < 2)) begin : g_bad_geometry
      $error("LINE_WIDTH/BURST_WIDTH must be an exact power of two of at least 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                  state;
  state_t                  state_n;
  logic [CNT_W-1:0]        cnt;
  logic [CNT_W-1:0]        cnt_n;
  logic                    take_read;
  logic                    take_write;
  logic                    beat;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [LINE_WIDTH-1:0]   wbuf;
  logic [LINE_WIDTH-1:0]   rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Simultaneous read and write is illegal from L2 and is simply not accepted.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    take_read  = 1'b0;
    take_write = 1'b0;
    beat       = 1'b0;
    case (state)
      IDLE: begin
        if (line_read_i ^ line_write_i) begin
          cnt_n      = '0;
          take_read  = line_read_i;
          take_write = line_write_i;
          state_n    = line_read_i ? READ : WRITE;
        end
      end
      READ, WRITE: begin
        if (mem_resp_i) begin
          beat  = 1'b1;
          cnt_n = cnt + CNT_W'(1);
          if (cnt == LAST_BEAT) begin
            state_n = DONE;
          end
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr <= '0;
    end else if (take_read || take_write) begin
      addr <= {line_addr_i[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
    end
  end

  always_ff @(posedge clk) begin
    if (take_write) begin
      wbuf <= line_wdata_i;
    end
  end

  // The assembled line survives DONE and is only disturbed by the next read beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (beat && (state == READ)) begin
      rdata[cnt*BURST_WIDTH +: BURST_WIDTH] <= mem_rdata_i;
    end
  end

  assign mem_read_o   = (state == READ);
  assign mem_write_o  = (state == WRITE);
  assign mem_addr_o   = addr;
  assign mem_wdata_o  = (state == WRITE) ? wbuf[cnt*BURST_WIDTH +: BURST_WIDTH] : '0;
  assign line_resp_o  = (state == DONE);
  assign line_rdata_o = rdata;

endmodule

// File: tb/tb_l2_cacheline_adaptor.sv
// Directed cycle-by-cycle vector bench for l2_cacheline_adaptor.
module tb_l2_cacheline_adaptor;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         line_read_i = 1'b0;
  logic         line_write_i = 1'b0;
  logic [31:0]  line_addr_i = '0;
  logic [255:0] line_wdata_i = '0;
  logic [255:0] line_rdata_o;
  logic         line_resp_o;
  logic         mem_read_o;
  logic         mem_write_o;
  logic [31:0]  mem_addr_o;
  logic [63:0]  mem_wdata_o;
  logic [63:0]  mem_rdata_i = '0;
  logic         mem_resp_i = 1'b0;

  l2_cacheline_adaptor #(
    .LINE_WIDTH (256),
    .BURST_WIDTH(64),
    .ADDR_WIDTH (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .line_read_i (line_read_i),
    .line_write_i(line_write_i),
    .line_addr_i (line_addr_i),
    .line_wdata_i(line_wdata_i),
    .line_rdata_o(line_rdata_o),
    .line_resp_o (line_resp_o),
    .mem_read_o  (mem_read_o),
    .mem_write_o (mem_write_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i),
    .mem_resp_i  (mem_resp_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         rd;
    logic         wr;
    logic [31:0]  addr;
    logic [255:0] wdata;
    logic [63:0]  mdata;
    logic         mresp;
    logic         e_rd;
    logic         e_wr;
    logic [31:0]  e_addr;
    logic [63:0]  e_wdata;
    logic         e_resp;
    logic         chk_line;
    logic [255:0] e_line;
  } vec_t;

  vec_t vq[$];
  int   tests = 0;
  int   fails = 0;

  function automatic logic [63:0] rep(input logic [3:0] n);
    return {16{n}};
  endfunction

  function automatic void add(input logic rd, input logic wr, input logic [31:0] a,
                              input logic [255:0] wd, input logic [63:0] md, input logic mr,
                              input logic erd, input logic ewr, input logic [31:0] ea,
                              input logic [63:0] ewd, input logic er);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = a; v.wdata = wd; v.mdata = md; v.mresp = mr;
    v.e_rd = erd; v.e_wr = ewr; v.e_addr = ea; v.e_wdata = ewd; v.e_resp = er;
    v.chk_line = 1'b0; v.e_line = '0;
    vq.push_back(v);
  endfunction

  function automatic void line(input logic [255:0] l);
    vq[vq.size()-1].chk_line = 1'b1;
    vq[vq.size()-1].e_line   = l;
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic erd, input logic ewr, input logic er);
    chk({tag, ".mem_read"},  256'(mem_read_o),  256'(erd));
    chk({tag, ".mem_write"}, 256'(mem_write_o), 256'(ewr));
    chk({tag, ".line_resp"}, 256'(line_resp_o), 256'(er));
  endtask

  logic [255:0] la, lb, le, wc, we;
  localparam logic [255:0] Z = '0;
  localparam logic [63:0]  z = '0;

  initial begin
    la = {rep(4'h4), rep(4'h3), rep(4'h2), rep(4'h1)};
    lb = {rep(4'h8), rep(4'h7), rep(4'h6), rep(4'h5)};
    wc = {rep(4'hD), rep(4'hC), rep(4'hB), rep(4'hA)};
    we = {rep(4'h9), rep(4'h8), rep(4'h7), rep(4'h6)};
    le = {rep(4'hD), rep(4'hC), rep(4'hB), rep(4'hA)};

    // Read with back-to-back beats in cycles 3..6.
    add(1,0,32'h0000_1234,Z,z,0,          0,0,32'h0,z,0);
    add(1,0,32'h0000_1234,Z,z,0,          1,0,32'h0000_1220,z,0);
    add(1,0,32'h0000_1234,Z,z,0,          1,0,32'h0000_1220,z,0);
    add(1,0,32'h0000_1234,Z,rep(4'h1),1,  1,0,32'h0000_1220,z,0);
    add(1,0,32'h0000_1234,Z,rep(4'h2),1,  1,0,32'h0000_1220,z,0);
    add(1,0,32'h0000_1234,Z,rep(4'h3),1,  1,0,32'h0000_1220,z,0);
    add(1,0,32'h0000_1234,Z,rep(4'h4),1,  1,0,32'h0000_1220,z,0);
    add(1,0,32'h0000_1234,Z,z,0,          0,0,32'h0000_1220,z,1); line(la);
    add(0,0,32'h0,Z,z,0,                  0,0,32'h0000_1220,z,0); line(la);

    // Read with gaps, request dropped after one cycle.
    add(1,0,32'h0000_2000,Z,z,0,          0,0,32'h0000_1220,z,0);
    add(0,0,32'h0,Z,z,0,                  1,0,32'h0000_2000,z,0);
    add(0,0,32'h0,Z,rep(4'h5),1,          1,0,32'h0000_2000,z,0); line(la);
    add(0,0,32'h0,Z,z,0,                  1,0,32'h0000_2000,z,0);
    line({rep(4'h4), rep(4'h3), rep(4'h2), rep(4'h5)});
    add(0,0,32'h0,Z,rep(4'h6),1,          1,0,32'h0000_2000,z,0);
    add(0,0,32'h0,Z,z,0,                  1,0,32'h0000_2000,z,0);
    add(0,0,32'h0,Z,z,0,                  1,0,32'h0000_2000,z,0);
    add(0,0,32'h0,Z,rep(4'h7),1,          1,0,32'h0000_2000,z,0);
    add(0,0,32'h0,Z,rep(4'h8),1,          1,0,32'h0000_2000,z,0);
    add(0,0,32'h0,Z,z,0,                  0,0,32'h0000_2000,z,1); line(lb);
    add(0,0,32'h0,Z,z,0,                  0,0,32'h0000_2000,z,0); line(lb);

    // Write; wdata input changes after the request to prove it is buffered.
    add(0,1,32'h8000_0040,wc,z,0,         0,0,32'h0000_2000,z,0);
    add(0,1,32'h8000_0040,Z,z,0,          0,1,32'h8000_0040,rep(4'hA),0);
    add(0,1,32'h8000_0040,Z,z,0,          0,1,32'h8000_0040,rep(4'hA),0);
    add(0,1,32'h8000_0040,Z,z,1,          0,1,32'h8000_0040,rep(4'hA),0);
    add(0,1,32'h8000_0040,Z,z,1,          0,1,32'h8000_0040,rep(4'hB),0);
    add(0,1,32'h8000_0040,Z,z,1,          0,1,32'h8000_0040,rep(4'hC),0);
    add(0,1,32'h8000_0040,Z,z,1,          0,1,32'h8000_0040,rep(4'hD),0);
    add(0,0,32'h0,Z,z,0,                  0,0,32'h8000_0040,z,1); line(lb);

    // Illegal simultaneous request, with stray mem_resp_i, for 5 cycles.
    for (int i = 0; i < 5; i++)
      add(1,1,32'hFFFF_FFFF,~Z,rep(4'hF),1, 0,0,32'h8000_0040,z,0);
    add(0,0,32'h0,Z,z,0,                  0,0,32'h8000_0040,z,0); line(lb);

    // Back-to-back: minimum-latency write, then read issued in the IDLE cycle after DONE.
    add(0,1,32'h0000_0100,we,z,0,         0,0,32'h8000_0040,z,0);
    add(0,0,32'h0,Z,z,1,                  0,1,32'h0000_0100,rep(4'h6),0);
    add(0,0,32'h0,Z,z,1,                  0,1,32'h0000_0100,rep(4'h7),0);
    add(0,0,32'h0,Z,z,1,                  0,1,32'h0000_0100,rep(4'h8),0);
    add(0,0,32'h0,Z,z,1,                  0,1,32'h0000_0100,rep(4'h9),0);
    add(0,0,32'h0,Z,z,0,                  0,0,32'h0000_0100,z,1);
    add(1,0,32'h0000_03FF,Z,z,0,          0,0,32'h0000_0100,z,0);
    add(0,0,32'h0,Z,rep(4'hA),1,          1,0,32'h0000_03E0,z,0);
    add(0,0,32'h0,Z,rep(4'hB),1,          1,0,32'h0000_03E0,z,0);
    add(0,0,32'h0,Z,rep(4'hC),1,          1,0,32'h0000_03E0,z,0);
    add(0,0,32'h0,Z,rep(4'hD),1,          1,0,32'h0000_03E0,z,0);
    add(0,0,32'h0,Z,z,0,                  0,0,32'h0000_03E0,z,1); line(le);
    add(0,0,32'h0,Z,z,0,                  0,0,32'h0000_03E0,z,0);

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_ctl("reset", 0, 0, 0);
    chk("reset.mem_addr",  256'(mem_addr_o),  256'(0));
    chk("reset.mem_wdata", 256'(mem_wdata_o), 256'(0));
    chk("reset.line_rdata", line_rdata_o, Z);
    rst = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      chk_ctl($sformatf("v%0d", i), vq[i].e_rd, vq[i].e_wr, vq[i].e_resp);
      chk($sformatf("v%0d.mem_addr", i),  256'(mem_addr_o),  256'(vq[i].e_addr));
      chk($sformatf("v%0d.mem_wdata", i), 256'(mem_wdata_o), 256'(vq[i].e_wdata));
      if (vq[i].chk_line)
        chk($sformatf("v%0d.line_rdata", i), line_rdata_o, vq[i].e_line);
      line_read_i  = vq[i].rd;
      line_write_i = vq[i].wr;
      line_addr_i  = vq[i].addr;
      line_wdata_i = vq[i].wdata;
      mem_rdata_i  = vq[i].mdata;
      mem_resp_i   = vq[i].mresp;
    end

    // Reset in the cycle after beat 1 of a read, then a fresh read.
    @(negedge clk);
    line_read_i = 1'b1; line_addr_i = 32'h0000_0040;
    @(negedge clk);
    chk_ctl("rstmid.c1", 1, 0, 0);
    line_read_i = 1'b0; mem_resp_i = 1'b1; mem_rdata_i = rep(4'hE);
    @(negedge clk);
    mem_rdata_i = rep(4'hF);
    @(negedge clk);
    chk_ctl("rstmid.c3", 1, 0, 0);
    chk("rstmid.c3.line_rdata", line_rdata_o, {rep(4'hD), rep(4'hC), rep(4'hF), rep(4'hE)});
    mem_resp_i = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk_ctl("rstmid.c4", 0, 0, 0);
    chk("rstmid.c4.line_rdata", line_rdata_o, Z);
    chk("rstmid.c4.mem_addr", 256'(mem_addr_o), 256'(0));
    rst = 1'b0; line_read_i = 1'b1; line_addr_i = 32'h0000_0060;
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      chk_ctl($sformatf("fresh.beat%0d", b), 1, 0, 0);
      chk($sformatf("fresh.beat%0d.mem_addr", b), 256'(mem_addr_o), 256'(32'h0000_0060));
      line_read_i = 1'b0; mem_resp_i = 1'b1; mem_rdata_i = rep(4'(b + 1));
    end
    @(negedge clk);
    mem_resp_i = 1'b0; mem_rdata_i = '0;
    chk_ctl("fresh.done", 0, 0, 1);
    chk("fresh.line_rdata", line_rdata_o, la);
    @(negedge clk);
    chk_ctl("fresh.idle", 0, 0, 0);
    chk("fresh.held_line", line_rdata_o, la);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
